// File: rtl/sliced_logic_unit.sv
// sliced_logic_unit
//   Multi-cycle bitwise logic unit (AND / OR / XOR / NOR). One SLICE-bit
//   slice of the operands is processed per clock, starting with the LSB slice.
//   The result and its zero flag are updated together, on the edge that
//   completes the last slice.
//
//   Handshake: a start seen in IDLE or DONE latches a, b and op. busy is high
//   for N = WIDTH/SLICE cycles. done is then high for exactly one cycle. A
//   start seen while busy is ignored.
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   request a new operation
//   op     in   [1:0] 00 AND, 01 OR, 10 XOR, 11 NOR
//   a, b   in   [WIDTH-1:0] operands
//   busy   out  slices are being processed
//   done   out  one-cycle pulse; out/zero were just updated
//   out    out  [WIDTH-1:0] registered result, held between operations
//   zero   out  registered, 1 iff out == 0
//
// WIDTH must be an integer multiple of SLICE.
module sliced_logic_unit #(
   parameter int WIDTH = 32,
   parameter int SLICE = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] out,
   output logic             zero
);

   localparam int N  = WIDTH / SLICE;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_q, b_q;
   logic [1:0]       op_q;
   logic [WIDTH-1:0] work, work_nxt;
   logic [SLICE-1:0] a_sl, b_sl, r_sl;
   logic             last;
   logic             accept;

   assign last   = (cnt == CW'(N - 1));
   // A new operation may be taken from IDLE or straight out of DONE.
   assign accept = start && ((state == S_IDLE) || (state == S_DONE));

   // Pick the current operand slices; only SLICE-wide gates follow.
   always_comb begin
      a_sl = '0;
      b_sl = '0;
      for (int i = 0; i < N; i++) begin
         if (cnt == CW'(i)) begin
            a_sl = a_q[i*SLICE +: SLICE];
            b_sl = b_q[i*SLICE +: SLICE];
         end
      end
   end

   always_comb begin
      case (op_q)
         2'b00:   r_sl = a_sl & b_sl;
         2'b01:   r_sl = a_sl | b_sl;
         2'b10:   r_sl = a_sl ^ b_sl;
         default: r_sl = ~(a_sl | b_sl);
      endcase
   end

   // Work word with this cycle's slice merged in. On the last slice this is
   // the complete result, so out can take it on the same edge.
   always_comb begin
      work_nxt = work;
      for (int i = 0; i < N; i++) begin
         if (cnt == CW'(i)) begin
            work_nxt[i*SLICE +: SLICE] = r_sl;
         end
      end
   end

   // FSM: state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM: next state
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  state_nxt = start ? S_BUSY : S_IDLE;
         S_BUSY:  state_nxt = last ? S_DONE : S_BUSY;
         S_DONE:  state_nxt = start ? S_BUSY : S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // FSM: outputs, decoded from the registered state only
   always_comb begin
      busy = (state == S_BUSY);
      done = (state == S_DONE);
   end

   // Datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q  <= '0;
         b_q  <= '0;
         op_q <= '0;
         cnt  <= '0;
         work <= '0;
         out  <= '0;
         zero <= 1'b1;
      end else if (accept) begin
         a_q  <= a;
         b_q  <= b;
         op_q <= op;
         cnt  <= '0;
         work <= '0;
      end else if (state == S_BUSY) begin
         work <= work_nxt;
         cnt  <= last ? '0 : cnt + CW'(1);
         if (last) begin
            out  <= work_nxt;
            zero <= (work_nxt == '0);
         end
      end
   end

endmodule

// File: tb/tb_sliced_logic_unit.sv
// Bench for sliced_logic_unit: three instances (32/8, 16/16, 64/8) share one
// clock and reset. Inputs are driven and outputs sampled on the falling edge.
module tb_sliced_logic_unit;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // per-instance stimulus: 0 = 32/8, 1 = 16/16, 2 = 64/8
   logic        start_v [3];
   logic [1:0]  op_v    [3];
   logic [63:0] a_v     [3];
   logic [63:0] b_v     [3];

   logic        busy32, done32, zero32;
   logic [31:0] out32;
   logic        busy16, done16, zero16;
   logic [15:0] out16;
   logic        busy64, done64, zero64;
   logic [63:0] out64;

   int inst_w [3] = '{32, 16, 64};
   int inst_n [3] = '{4, 1, 8};

   sliced_logic_unit #(.WIDTH(32), .SLICE(8)) u32 (
      .clk(clk), .rst_n(rst_n), .start(start_v[0]), .op(op_v[0]),
      .a(a_v[0][31:0]), .b(b_v[0][31:0]),
      .busy(busy32), .done(done32), .out(out32), .zero(zero32));

   sliced_logic_unit #(.WIDTH(16), .SLICE(16)) u16 (
      .clk(clk), .rst_n(rst_n), .start(start_v[1]), .op(op_v[1]),
      .a(a_v[1][15:0]), .b(b_v[1][15:0]),
      .busy(busy16), .done(done16), .out(out16), .zero(zero16));

   sliced_logic_unit #(.WIDTH(64), .SLICE(8)) u64 (
      .clk(clk), .rst_n(rst_n), .start(start_v[2]), .op(op_v[2]),
      .a(a_v[2]), .b(b_v[2]),
      .busy(busy64), .done(done64), .out(out64), .zero(zero64));

   int checks = 0;
   int errors = 0;

   typedef struct {
      int          inst;
      logic [1:0]  op;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] exp;
      logic        exp_zero;
   } vec_t;

   vec_t vecs [7];

   function automatic logic [63:0] wmask(input int w);
      return (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
   endfunction

   // Whole-word reference: the slicing is invisible at this level.
   function automatic logic [63:0] ref_model(input logic [1:0] op,
                                             input logic [63:0] a,
                                             input logic [63:0] b,
                                             input int w);
      logic [63:0] r;
      case (op)
         2'b00:   r = a & b;
         2'b01:   r = a | b;
         2'b10:   r = a ^ b;
         default: r = ~(a | b);
      endcase
      return r & wmask(w);
   endfunction

   function automatic logic get_busy(input int inst);
      case (inst)
         0:       return busy32;
         1:       return busy16;
         default: return busy64;
      endcase
   endfunction

   function automatic logic get_done(input int inst);
      case (inst)
         0:       return done32;
         1:       return done16;
         default: return done64;
      endcase
   endfunction

   function automatic logic get_zero(input int inst);
      case (inst)
         0:       return zero32;
         1:       return zero16;
         default: return zero64;
      endcase
   endfunction

   function automatic logic [63:0] get_out(input int inst);
      case (inst)
         0:       return {32'h0, out32};
         1:       return {48'h0, out16};
         default: return out64;
      endcase
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive_start(input int inst, input logic [1:0] op,
                              input logic [63:0] a, input logic [63:0] b);
      start_v[inst] = 1'b1;
      op_v[inst]    = op;
      a_v[inst]     = a;
      b_v[inst]     = b;
   endtask

   // After the start edge has been taken: drop start and scramble the operand
   // inputs, which must not disturb the operation in flight.
   task automatic release_start(input int inst);
      start_v[inst] = 1'b0;
      op_v[inst]    = 2'($urandom_range(0, 3));
      a_v[inst]     = {$urandom(), $urandom()};
      b_v[inst]     = {$urandom(), $urandom()};
   endtask

   // Called on a falling edge after the start edge. Returns on the falling
   // edge inside the done cycle, or after a bounded number of cycles.
   task automatic wait_done(input int inst, input logic [63:0] prev,
                            output int bc, output bit seen, output bit partial);
      bc      = 0;
      seen    = 1'b0;
      partial = 1'b0;
      for (int t = 0; t < 40; t++) begin
         if (get_done(inst)) begin
            seen = 1'b1;
            break;
         end
         if (get_busy(inst)) bc++;
         if (get_out(inst) !== prev) partial = 1'b1;
         @(negedge clk);
      end
   endtask

   task automatic run_op(input int inst, input logic [1:0] op,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] exp, input logic exp_zero,
                         input string tag, input bit full_checks);
      logic [63:0] prev;
      int          bc;
      bit          seen, partial;
      prev = get_out(inst);
      drive_start(inst, op, a, b);
      @(negedge clk);
      release_start(inst);
      wait_done(inst, prev, bc, seen, partial);
      check({tag, "_done_seen"}, 64'(seen), 64'd1);
      check({tag, "_busy_cycles"}, 64'(bc), 64'(inst_n[inst]));
      check({tag, "_out"}, get_out(inst), exp);
      check({tag, "_zero"}, 64'(get_zero(inst)), 64'(exp_zero));
      if (full_checks) begin
         check({tag, "_no_partial"}, 64'(partial), 64'd0);
         @(negedge clk);
         check({tag, "_done_one_cycle"}, 64'(get_done(inst)), 64'd0);
         check({tag, "_idle_after"}, 64'(get_busy(inst)), 64'd0);
      end else begin
         @(negedge clk);
      end
   endtask

   initial begin
      logic [63:0] prev;
      int          bc, bc0, extra_done, extra_busy;
      bit          seen, partial;

      for (int i = 0; i < 3; i++) begin
         start_v[i] = 1'b0;
         op_v[i]    = 2'b00;
         a_v[i]     = '0;
         b_v[i]     = '0;
      end

      vecs[0] = '{0, 2'b11, 64'hF0F0F0F0, 64'h0F0F0F00, 64'h0000000F, 1'b0};
      vecs[1] = '{0, 2'b00, 64'hFFFF0000, 64'h0000FFFF, 64'h00000000, 1'b1};
      vecs[2] = '{0, 2'b01, 64'h00000001, 64'h80000000, 64'h80000001, 1'b0};
      vecs[3] = '{1, 2'b11, 64'h0000, 64'h0000, 64'hFFFF, 1'b0};
      vecs[4] = '{2, 2'b00, 64'h8000000000000001, 64'h8000000000000001,
                  64'h8000000000000001, 1'b0};
      vecs[5] = '{2, 2'b10, 64'h0123456789ABCDEF, 64'hFF00000000000000,
                  64'hFE23456789ABCDEF, 1'b0};
      vecs[6] = '{1, 2'b10, 64'hA5A5, 64'hA5A5, 64'h0000, 1'b1};

      // reset state
      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("rst_out_%0d", i), get_out(i), 64'd0);
         check($sformatf("rst_zero_%0d", i), 64'(get_zero(i)), 64'd1);
         check($sformatf("rst_busy_%0d", i), 64'(get_busy(i)), 64'd0);
         check($sformatf("rst_done_%0d", i), 64'(get_done(i)), 64'd0);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // directed vectors
      for (int v = 0; v < 7; v++) begin
         run_op(vecs[v].inst, vecs[v].op, vecs[v].a, vecs[v].b,
                vecs[v].exp, vecs[v].exp_zero, $sformatf("vec%0d", v), 1'b1);
      end

      // back-to-back: AND, then XOR accepted straight out of DONE
      prev = get_out(0);
      drive_start(0, 2'b00, 64'hFFFF0000, 64'h0000FFFF);
      @(negedge clk);
      release_start(0);
      wait_done(0, prev, bc, seen, partial);
      check("b2b_first_done", 64'(seen), 64'd1);
      check("b2b_first_out", get_out(0), 64'h0);
      check("b2b_first_zero", 64'(get_zero(0)), 64'd1);
      prev = get_out(0);
      drive_start(0, 2'b10, 64'h12345678, 64'hFFFFFFFF);
      @(negedge clk);
      release_start(0);
      check("b2b_accepted_busy", 64'(get_busy(0)), 64'd1);
      wait_done(0, prev, bc, seen, partial);
      check("b2b_second_done", 64'(seen), 64'd1);
      check("b2b_second_busy_cycles", 64'(bc), 64'd4);
      check("b2b_second_out", get_out(0), 64'hEDCBA987);
      check("b2b_second_zero", 64'(get_zero(0)), 64'd0);
      check("b2b_no_partial", 64'(partial), 64'd0);
      @(negedge clk);

      // start pulse while busy is ignored
      prev = get_out(0);
      drive_start(0, 2'b01, 64'h00000001, 64'h80000000);
      @(negedge clk);
      bc0 = get_busy(0) ? 1 : 0;
      drive_start(0, 2'b00, 64'hFFFFFFFF, 64'hFFFFFFFF);
      @(negedge clk);
      release_start(0);
      wait_done(0, prev, bc, seen, partial);
      check("ign_done", 64'(seen), 64'd1);
      check("ign_busy_cycles", 64'(bc0 + bc), 64'd4);
      check("ign_out", get_out(0), 64'h80000001);
      check("ign_zero", 64'(get_zero(0)), 64'd0);
      extra_done = 0;
      extra_busy = 0;
      for (int t = 0; t < 6; t++) begin
         @(negedge clk);
         if (get_done(0)) extra_done++;
         if (get_busy(0)) extra_busy++;
      end
      check("ign_single_done", 64'(extra_done), 64'd0);
      check("ign_no_rerun", 64'(extra_busy), 64'd0);

      // asynchronous reset during an operation
      drive_start(0, 2'b10, 64'h12345678, 64'h0);
      @(negedge clk);
      release_start(0);
      @(negedge clk);
      check("abort_busy_before", 64'(get_busy(0)), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check("abort_out", get_out(0), 64'd0);
      check("abort_zero", 64'(get_zero(0)), 64'd1);
      check("abort_busy", 64'(get_busy(0)), 64'd0);
      check("abort_done", 64'(get_done(0)), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      extra_done = 0;
      extra_busy = 0;
      for (int t = 0; t < 10; t++) begin
         @(negedge clk);
         if (get_done(0)) extra_done++;
         if (get_busy(0)) extra_busy++;
      end
      check("abort_no_done", 64'(extra_done), 64'd0);
      check("abort_stays_idle", 64'(extra_busy), 64'd0);

      // randomized operations against the reference model
      for (int r = 0; r < 40; r++) begin
         int          inst;
         logic [1:0]  op;
         logic [63:0] a, b, exp;
         inst = $urandom_range(0, 2);
         op   = 2'($urandom_range(0, 3));
         a    = {$urandom(), $urandom()} & wmask(inst_w[inst]);
         b    = {$urandom(), $urandom()} & wmask(inst_w[inst]);
         // occasionally force equal operands so AND/XOR hit the zero flag
         if ($urandom_range(0, 3) == 0) b = a;
         exp  = ref_model(op, a, b, inst_w[inst]);
         run_op(inst, op, a, b, exp, (exp == 64'd0), $sformatf("rnd%0d", r), 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
